// File: rtl/sdma_inst_pkg.sv
// Shared definitions for the SDMA instruction dispatcher: mode field placement,
// assembler states and error cause codes.
// Pure declarations, no logic; no latency or backpressure of its own.
package sdma_inst_pkg;

    // sdmamode sits in the low bits of the first beat of every instruction.
    localparam int MODE_LSB   = 0;
    localparam int MODE_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ASM  = 2'd1,
        ST_DROP = 2'd2
    } asm_state_t;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_SHORT  = 3'd1;
    localparam logic [2:0] ERR_LONG   = 3'd2;
    localparam logic [2:0] ERR_MODE   = 3'd3;
    localparam logic [2:0] ERR_PARITY = 3'd4;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/sdma_inst_fifo.sv
// Instruction queue: DEPTH x W storage with full/empty and same-cycle push+pop.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: push is ignored when full; the caller gates push on !full.
module sdma_inst_fifo #(
    parameter int W     = 512,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_vld,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push_vld && !full;
    assign do_pop   = pop_vld && !empty;
    assign head_dat = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdma_inst_dispatcher.sv
// Assembles BUS_W beats into INST_W instructions, queues them and dispatches the head to the channel named by its sdmamode.
// Latency: last beat accepted in cycle N (queue empty) -> channel valid in cycle N+1; errors reported in the cycle after the offending beat.
// Backpressure: beat ready is simply !queue_full; head is held until the addressed channel is ready. Option: SDMA_INST_PARITY_CHK_EN adds per-beat even parity.
module sdma_inst_dispatcher
    import sdma_inst_pkg::*;
#(
    parameter int BUS_W  = 32,
    parameter int INST_W = 512,
    parameter int DEPTH  = 4,
    parameter int NUM_CH = 4,
    parameter int MODE_W = MODE_WIDTH
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_sdi_beat_vld,
    input  logic [BUS_W-1:0]  i_sdi_beat_data,
    input  logic              i_sdi_beat_last,
`ifdef SDMA_INST_PARITY_CHK_EN
    input  logic              i_sdi_beat_par,
`endif
    output logic              o_sdi_beat_rdy,
    output logic [INST_W-1:0] o_sdi_inst,
    output logic [MODE_W-1:0] o_sdi_sdmamode,
    output logic [NUM_CH-1:0] o_sdi_inst_vld,
    input  logic [NUM_CH-1:0] i_sdi_inst_rdy,
    output logic              o_sdi_err,
    output logic [2:0]        o_sdi_err_code,
    output logic              o_sdi_busy
);

    localparam int BEATS = ceil_div(INST_W, BUS_W);
    localparam int BUF_W = BEATS * BUS_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    asm_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic              par_err_q, par_err_d;
    logic [BUF_W-1:0]  merged_buf;
    logic              merged_par;
    logic [MODE_W-1:0] cmp_mode;
    logic              beat_fire;
    logic              beat_par_bad;
    logic              push;
    logic              err_now;
    logic [2:0]        code_now;
    logic              err_q;
    logic [2:0]        err_code_q;

    logic [INST_W-1:0] head_dat;
    logic [MODE_W-1:0] head_mode;
    logic              q_full;
    logic              q_empty;
    logic              pop;

    assign o_sdi_beat_rdy = !q_full;
    assign beat_fire      = i_sdi_beat_vld && o_sdi_beat_rdy;

`ifdef SDMA_INST_PARITY_CHK_EN
    assign beat_par_bad = (^i_sdi_beat_data) != i_sdi_beat_par;
`else
    assign beat_par_bad = 1'b0;
`endif

    // Current beat merged into the partial instruction at its slot.
    always_comb begin
        merged_buf = buf_q;
        for (int k = 0; k < BEATS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                merged_buf[k*BUS_W +: BUS_W] = i_sdi_beat_data;
            end
        end
        merged_par = par_err_q | beat_par_bad;
        cmp_mode   = merged_buf[MODE_LSB +: MODE_W];
    end

    // Assembler next-state: collect, complete, or flag short/long/mode/parity faults.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        par_err_d = par_err_q;
        push      = 1'b0;
        err_now   = 1'b0;
        code_now  = ERR_NONE;
        if (beat_fire) begin
            case (state_q)
                ST_IDLE, ST_ASM: begin
                    buf_d     = merged_buf;
                    par_err_d = merged_par;
                    if (cnt_q == LAST_CNT) begin
                        state_d   = i_sdi_beat_last ? ST_IDLE : ST_DROP;
                        cnt_d     = '0;
                        par_err_d = 1'b0;
                        err_now   = 1'b1;
                        if (!i_sdi_beat_last) begin
                            code_now = ERR_LONG;
                        end else if (merged_par) begin
                            code_now = ERR_PARITY;
                        end else if (32'(cmp_mode) >= NUM_CH) begin
                            code_now = ERR_MODE;
                        end else begin
                            err_now = 1'b0;
                            push    = 1'b1;
                        end
                    end else if (i_sdi_beat_last) begin
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                        par_err_d = 1'b0;
                        err_now   = 1'b1;
                        code_now  = ERR_SHORT;
                    end else begin
                        state_d = ST_ASM;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                ST_DROP: begin
                    if (i_sdi_beat_last) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Assembler state, beat counter, partial instruction and parity flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            buf_q     <= '0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            par_err_q <= par_err_d;
        end
    end

    // Error pulse for one cycle; cause code sticks until the next error.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            err_q <= err_now;
            if (err_now) begin
                err_code_q <= code_now;
            end
        end
    end

    assign o_sdi_err      = err_q;
    assign o_sdi_err_code = err_code_q;

    sdma_inst_fifo #(
        .W     (INST_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .push_vld (push),
        .push_dat (merged_buf[INST_W-1:0]),
        .pop_vld  (pop),
        .head_dat (head_dat),
        .full     (q_full),
        .empty    (q_empty)
    );

    assign head_mode = head_dat[MODE_LSB +: MODE_W];

    // Head dispatch: one-hot valid on the addressed channel, data zeroed when empty.
    always_comb begin
        o_sdi_inst     = q_empty ? '0 : head_dat;
        o_sdi_sdmamode = q_empty ? '0 : head_mode;
        o_sdi_inst_vld = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            o_sdi_inst_vld[ch] = !q_empty && (32'(head_mode) == ch);
        end
        pop = |(o_sdi_inst_vld & i_sdi_inst_rdy);
    end

    assign o_sdi_busy = (state_q != ST_IDLE) || !q_empty;

endmodule

// File: tb/tb_sdma_inst_dispatcher.sv
module tb_sdma_inst_dispatcher;

    localparam int BUS_W  = 32;
    localparam int INST_W = 128;
    localparam int DEPTH  = 2;
    localparam int NUM_CH = 4;
    localparam int MODE_W = 4;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              beat_vld = 1'b0;
    logic [BUS_W-1:0]  beat_dat = '0;
    logic              beat_last = 1'b0;
    logic [NUM_CH-1:0] inst_rdy = '0;
    logic              beat_rdy;
    logic [INST_W-1:0] inst;
    logic [MODE_W-1:0] sdmamode;
    logic [NUM_CH-1:0] inst_vld;
    logic              err;
    logic [2:0]        err_code;
    logic              busy;
`ifdef SDMA_INST_PARITY_CHK_EN
    logic              beat_par;
    assign beat_par = ^beat_dat;
`endif

    always #5 i_clk = ~i_clk;

    sdma_inst_dispatcher #(
        .BUS_W  (BUS_W),
        .INST_W (INST_W),
        .DEPTH  (DEPTH),
        .NUM_CH (NUM_CH),
        .MODE_W (MODE_W)
    ) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_sdi_beat_vld  (beat_vld),
        .i_sdi_beat_data (beat_dat),
        .i_sdi_beat_last (beat_last),
`ifdef SDMA_INST_PARITY_CHK_EN
        .i_sdi_beat_par  (beat_par),
`endif
        .o_sdi_beat_rdy  (beat_rdy),
        .o_sdi_inst      (inst),
        .o_sdi_sdmamode  (sdmamode),
        .o_sdi_inst_vld  (inst_vld),
        .i_sdi_inst_rdy  (inst_rdy),
        .o_sdi_err       (err),
        .o_sdi_err_code  (err_code),
        .o_sdi_busy      (busy)
    );

    typedef struct {
        logic        vld;
        logic [31:0] dat;
        logic        last;
        logic [3:0]  irdy;
        logic        brdy;
        logic [3:0]  ivld;
        logic [3:0]  mode;
        logic        err;
        logic [2:0]  code;
        logic        busy;
    } vec_t;

    vec_t vt[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic vec_t mkv(input logic v, input logic [31:0] d, input logic l,
                                 input logic [3:0] ir, input logic br, input logic [3:0] iv,
                                 input logic [3:0] md, input logic e, input logic [2:0] c,
                                 input logic b);
        vec_t r;
        r.vld = v; r.dat = d; r.last = l; r.irdy = ir; r.brdy = br;
        r.ivld = iv; r.mode = md; r.err = e; r.code = c; r.busy = b;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send_beat(input logic [31:0] d, input logic l, input string nm);
        logic ok;
        logic acc;
        acc = 1'b0;
        beat_vld  = 1'b1;
        beat_dat  = d;
        beat_last = l;
        for (int w = 0; w < 50; w++) begin
            ok = beat_rdy;
            @(posedge i_clk);
            #1;
            if (ok) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) chk({nm, " beat accept timeout"}, 128'(acc), 128'(1));
        beat_vld  = 1'b0;
        beat_last = 1'b0;
    endtask

    task automatic send_inst(input logic [127:0] ins, input string nm);
        for (int k = 0; k < 4; k++) begin
            send_beat(ins[k*32 +: 32], (k == 3), nm);
        end
    endtask

    logic [127:0] inst_f, inst_g, inst_h, inst_j, inst_l;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        inst_f = {32'hF3F3_F3F3, 32'hF2F2_F2F2, 32'hF1F1_F1F1, 32'hF0F0_0000};
        inst_g = {32'h6363_6363, 32'h6262_6262, 32'h6161_6161, 32'h6060_0001};
        inst_h = {32'h7373_7373, 32'h7272_7272, 32'h7171_7171, 32'h7070_0003};
        inst_j = {32'h9393_9393, 32'h9292_9292, 32'h9191_9191, 32'h9090_0002};
        inst_l = {32'hABAB_0003, 32'hCDCD_0002, 32'hEFEF_0001, 32'h1234_5673};

        // Single instruction mode 2, dispatched and popped immediately.
        vt.push_back(mkv(1, 32'h1111_0002, 0, 4'b0100, 1, 4'b0000, 0, 0, 0, 1));
        vt.push_back(mkv(1, 32'h2222_2222, 0, 4'b0100, 1, 4'b0000, 0, 0, 0, 1));
        vt.push_back(mkv(1, 32'h3333_3333, 0, 4'b0100, 1, 4'b0000, 0, 0, 0, 1));
        vt.push_back(mkv(1, 32'h4444_4444, 1, 4'b0100, 1, 4'b0100, 2, 0, 0, 1));
        vt.push_back(mkv(0, 32'h0,         0, 4'b0100, 1, 4'b0000, 0, 0, 0, 0));
        // Short instruction: last on beat 2.
        vt.push_back(mkv(1, 32'h0000_0001, 0, 4'b0000, 1, 4'b0000, 0, 0, 0, 1));
        vt.push_back(mkv(1, 32'h0000_00B1, 1, 4'b0000, 1, 4'b0000, 0, 1, 1, 0));
        vt.push_back(mkv(0, 32'h0,         0, 4'b0000, 1, 4'b0000, 0, 0, 1, 0));
        // Long instruction: 6 beats, error at beat 4, 5-6 dropped.
        vt.push_back(mkv(1, 32'h0C0C_0001, 0, 4'b0010, 1, 4'b0000, 0, 0, 1, 1));
        vt.push_back(mkv(1, 32'h0C0C_0011, 0, 4'b0010, 1, 4'b0000, 0, 0, 1, 1));
        vt.push_back(mkv(1, 32'h0C0C_0021, 0, 4'b0010, 1, 4'b0000, 0, 0, 1, 1));
        vt.push_back(mkv(1, 32'h0C0C_0031, 0, 4'b0010, 1, 4'b0000, 0, 1, 2, 1));
        vt.push_back(mkv(1, 32'h0C0C_0041, 0, 4'b0010, 1, 4'b0000, 0, 0, 2, 1));
        vt.push_back(mkv(1, 32'h0C0C_0051, 1, 4'b0010, 1, 4'b0000, 0, 0, 2, 0));
        // Following instruction, mode 1, dispatches normally.
        vt.push_back(mkv(1, 32'h0D0D_0001, 0, 4'b0010, 1, 4'b0000, 0, 0, 2, 1));
        vt.push_back(mkv(1, 32'h0D0D_0011, 0, 4'b0010, 1, 4'b0000, 0, 0, 2, 1));
        vt.push_back(mkv(1, 32'h0D0D_0021, 0, 4'b0010, 1, 4'b0000, 0, 0, 2, 1));
        vt.push_back(mkv(1, 32'h0D0D_0031, 1, 4'b0010, 1, 4'b0010, 1, 0, 2, 1));
        vt.push_back(mkv(0, 32'h0,         0, 4'b0010, 1, 4'b0000, 0, 0, 2, 0));
        // Mode 5 on a 4-channel build: rejected.
        vt.push_back(mkv(1, 32'h5555_0005, 0, 4'b1111, 1, 4'b0000, 0, 0, 2, 1));
        vt.push_back(mkv(1, 32'h5555_1111, 0, 4'b1111, 1, 4'b0000, 0, 0, 2, 1));
        vt.push_back(mkv(1, 32'h5555_2222, 0, 4'b1111, 1, 4'b0000, 0, 0, 2, 1));
        vt.push_back(mkv(1, 32'h5555_3333, 1, 4'b1111, 1, 4'b0000, 0, 1, 3, 0));
        vt.push_back(mkv(0, 32'h0,         0, 4'b1111, 1, 4'b0000, 0, 0, 3, 0));

        // Reset state.
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst inst_vld", 128'(inst_vld), 128'(0));
        chk("rst inst", inst, 128'(0));
        chk("rst sdmamode", 128'(sdmamode), 128'(0));
        chk("rst err", 128'(err), 128'(0));
        chk("rst err_code", 128'(err_code), 128'(0));
        chk("rst busy", 128'(busy), 128'(0));
        #2 i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        chk("rst beat_rdy", 128'(beat_rdy), 128'(1));

        // Table-driven vectors: apply, clock, check post-edge outputs.
        for (int i = 0; i < vt.size(); i++) begin
            beat_vld  = vt[i].vld;
            beat_dat  = vt[i].dat;
            beat_last = vt[i].last;
            inst_rdy  = vt[i].irdy;
            @(posedge i_clk);
            #1;
            chk($sformatf("v%0d beat_rdy", i), 128'(beat_rdy), 128'(vt[i].brdy));
            chk($sformatf("v%0d inst_vld", i), 128'(inst_vld), 128'(vt[i].ivld));
            chk($sformatf("v%0d err", i), 128'(err), 128'(vt[i].err));
            chk($sformatf("v%0d err_code", i), 128'(err_code), 128'(vt[i].code));
            chk($sformatf("v%0d busy", i), 128'(busy), 128'(vt[i].busy));
            if (vt[i].ivld != 4'b0000)
                chk($sformatf("v%0d sdmamode", i), 128'(sdmamode), 128'(vt[i].mode));
            if (i == 3)
                chk("v3 inst data", inst,
                    {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_0002});
        end
        beat_vld = 1'b0; beat_last = 1'b0; inst_rdy = '0;

        // Queue fills after two instructions; a channel-0 pop frees a slot.
        send_inst(inst_f, "F");
        chk("fill F inst_vld", 128'(inst_vld), 128'(4'b0001));
        chk("fill F inst", inst, inst_f);
        chk("fill F beat_rdy", 128'(beat_rdy), 128'(1));
        send_inst(inst_g, "G");
        chk("fill G beat_rdy", 128'(beat_rdy), 128'(0));
        chk("fill G inst_vld", 128'(inst_vld), 128'(4'b0001));
        beat_vld = 1'b1;
        beat_dat = inst_h[31:0];
        for (int c = 0; c < 3; c++) begin
            @(posedge i_clk);
            #1;
            chk($sformatf("full hold%0d beat_rdy", c), 128'(beat_rdy), 128'(0));
            chk($sformatf("full hold%0d inst", c), inst, inst_f);
        end
        beat_vld = 1'b0;
        inst_rdy = 4'b0001;
        @(posedge i_clk);
        #1;
        inst_rdy = 4'b0000;
        chk("pop F beat_rdy", 128'(beat_rdy), 128'(1));
        chk("pop F inst_vld", 128'(inst_vld), 128'(4'b0010));
        chk("pop F inst", inst, inst_g);
        send_inst(inst_h, "H");
        chk("H beat_rdy", 128'(beat_rdy), 128'(0));
        inst_rdy = 4'b0010;
        @(posedge i_clk);
        #1;
        chk("pop G inst_vld", 128'(inst_vld), 128'(4'b1000));
        chk("pop G inst", inst, inst_h);
        chk("pop G sdmamode", 128'(sdmamode), 128'(3));
        inst_rdy = 4'b1000;
        @(posedge i_clk);
        #1;
        inst_rdy = 4'b0000;
        chk("drain inst_vld", 128'(inst_vld), 128'(0));
        chk("drain busy", 128'(busy), 128'(0));

        // Reset while beat 3 of a partial instruction is presented, with one queued.
        send_inst(inst_j, "J");
        chk("J inst_vld", 128'(inst_vld), 128'(4'b0100));
        send_beat(32'h8080_0001, 1'b0, "K0");
        send_beat(32'h8181_8181, 1'b0, "K1");
        beat_vld = 1'b1;
        beat_dat = 32'h8282_8282;
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        chk("midrst inst_vld", 128'(inst_vld), 128'(0));
        chk("midrst inst", inst, 128'(0));
        chk("midrst sdmamode", 128'(sdmamode), 128'(0));
        chk("midrst err", 128'(err), 128'(0));
        chk("midrst err_code", 128'(err_code), 128'(0));
        chk("midrst busy", 128'(busy), 128'(0));
        beat_vld = 1'b0;
        @(posedge i_clk);
        #3 i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        chk("postrst beat_rdy", 128'(beat_rdy), 128'(1));
        chk("postrst err", 128'(err), 128'(0));
        chk("postrst busy", 128'(busy), 128'(0));
        inst_rdy = 4'b1000;
        send_inst(inst_l, "L");
        chk("L inst_vld", 128'(inst_vld), 128'(4'b1000));
        chk("L inst", inst, inst_l);
        chk("L err", 128'(err), 128'(0));
        @(posedge i_clk);
        #1;
        chk("L popped inst_vld", 128'(inst_vld), 128'(0));
        chk("L popped busy", 128'(busy), 128'(0));
        inst_rdy = 4'b0000;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
